// File: rtl/intersection_controller_if.sv
// ============================================================================
//  Module   : intersection_controller_if
//  Purpose  : Request/strobe inputs and light-head outputs of the intersection
//             controller, grouped for connection between controller and host.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface intersection_controller_if;
    logic       tick_en;
    logic       ew_req;
    logic       ped_req;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       walk;
    logic [2:0] phase;

    modport master (
        output tick_en, ew_req, ped_req,
        input  ns_light, ew_light, walk, phase
    );

    modport slave (
        input  tick_en, ew_req, ped_req,
        output ns_light, ew_light, walk, phase
    );
endinterface

`default_nettype wire

// File: rtl/intersection_controller.sv
// ============================================================================
//  Module   : intersection_controller
//  Purpose  : Two-road intersection sequencer; NS rests green, EW and walk
//             phases are granted on latched requests. Optional pedestrian
//             phase enabled by defining TRAFFIC_PED_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module intersection_controller #(
    parameter int TIMER_W   = 5,
    parameter int MIN_GREEN = 8,
    parameter int EW_GREEN  = 6,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int PED_T     = 5
) (
    input  wire logic               clk,
    input  wire logic               rstb,
    intersection_controller_if.slave bus
);

    localparam logic [2:0] c_st_allred_b  = 3'd0;
    localparam logic [2:0] c_st_ns_green  = 3'd1;
    localparam logic [2:0] c_st_ns_yellow = 3'd2;
    localparam logic [2:0] c_st_allred_a  = 3'd3;
    localparam logic [2:0] c_st_ew_green  = 3'd4;
    localparam logic [2:0] c_st_ew_yellow = 3'd5;
    localparam logic [2:0] c_st_ped_walk  = 3'd6;

    localparam logic [1:0] c_red    = 2'b00;
    localparam logic [1:0] c_green  = 2'b01;
    localparam logic [1:0] c_yellow = 2'b10;

    // Timer value on the tick that completes each phase
    localparam logic [TIMER_W-1:0] c_min_last    = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] c_ewg_last    = TIMER_W'(EW_GREEN - 1);
    localparam logic [TIMER_W-1:0] c_yel_last    = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] c_allred_last = TIMER_W'(ALLRED_T - 1);
    localparam logic [TIMER_W-1:0] c_ped_last    = TIMER_W'(PED_T - 1);
    localparam logic [TIMER_W-1:0] c_timer_max   = '1;

    logic [2:0]         r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_ew_pend;
    logic               r_ped_pend;
    logic [2:0]         w_next_state;
    logic               w_state_chg;

    always_comb begin
        w_next_state = r_state;
        if (bus.tick_en) begin
            case (r_state)
                c_st_allred_b:
                    if (r_timer == c_allred_last) w_next_state = c_st_ns_green;
                c_st_ns_green:
                    if ((r_timer >= c_min_last) && (r_ew_pend || r_ped_pend))
                        w_next_state = c_st_ns_yellow;
                c_st_ns_yellow:
                    if (r_timer == c_yel_last) w_next_state = c_st_allred_a;
                c_st_allred_a:
`ifdef TRAFFIC_PED_EN
                    if (r_timer == c_allred_last)
                        w_next_state = r_ped_pend ? c_st_ped_walk : c_st_ew_green;
`else
                    if (r_timer == c_allred_last) w_next_state = c_st_ew_green;
`endif
                c_st_ped_walk:
                    if (r_timer == c_ped_last)
                        w_next_state = r_ew_pend ? c_st_ew_green : c_st_ns_green;
                c_st_ew_green:
                    if (r_timer == c_ewg_last) w_next_state = c_st_ew_yellow;
                c_st_ew_yellow:
                    if (r_timer == c_yel_last) w_next_state = c_st_allred_b;
                default:
                    w_next_state = c_st_allred_b;
            endcase
        end
    end

    assign w_state_chg = (w_next_state != r_state);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= c_st_allred_b;
            r_timer <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_state_chg)
                r_timer <= '0;
            else if (bus.tick_en && (r_timer != c_timer_max))
                r_timer <= r_timer + 1'b1;
        end
    end

    // Clearing on phase entry takes priority over a request on the same edge
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_ew_pend <= 1'b0;
        end else if (w_state_chg && (w_next_state == c_st_ew_green)) begin
            r_ew_pend <= 1'b0;
        end else if (bus.ew_req && (r_state != c_st_ew_green) &&
                     (r_state != c_st_ew_yellow)) begin
            r_ew_pend <= 1'b1;
        end
    end

`ifdef TRAFFIC_PED_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_ped_pend <= 1'b0;
        end else if (w_state_chg && (w_next_state == c_st_ped_walk)) begin
            r_ped_pend <= 1'b0;
        end else if (bus.ped_req && (r_state != c_st_ped_walk)) begin
            r_ped_pend <= 1'b1;
        end
    end

    assign bus.walk = (r_state == c_st_ped_walk);
`else
    logic w_unused_ped;
    assign w_unused_ped = bus.ped_req;
    assign r_ped_pend   = 1'b0;
    assign bus.walk     = 1'b0;
`endif

    always_comb begin
        bus.ns_light = c_red;
        bus.ew_light = c_red;
        case (r_state)
            c_st_ns_green:  bus.ns_light = c_green;
            c_st_ns_yellow: bus.ns_light = c_yellow;
            c_st_ew_green:  bus.ew_light = c_green;
            c_st_ew_yellow: bus.ew_light = c_yellow;
            default: ;
        endcase
    end

    assign bus.phase = r_state;

endmodule

`default_nettype wire

// File: tb/tb_intersection_controller.sv
// ============================================================================
//  Module   : tb_intersection_controller
//  Purpose  : Randomized self-checking bench for intersection_controller using
//             a phase/tick-count reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_intersection_controller;

    localparam int TIMER_W   = 5;
    localparam int MIN_GREEN = 8;
    localparam int EW_GREEN  = 6;
    localparam int YELLOW_T  = 3;
    localparam int ALLRED_T  = 2;
    localparam int PED_T     = 5;
`ifdef TRAFFIC_PED_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    // Phase codes as published for the debug output
    localparam int P_ARB = 0, P_NSG = 1, P_NSY = 2, P_ARA = 3;
    localparam int P_EWG = 4, P_EWY = 5, P_PED = 6;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    intersection_controller_if u_if ();

    intersection_controller #(
        .TIMER_W(TIMER_W), .MIN_GREEN(MIN_GREEN), .EW_GREEN(EW_GREEN),
        .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .PED_T(PED_T)
    ) u_dut (
        .clk (clk),
        .rstb(rstb),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: current phase, ticks spent in it, latched requests
    int m_phase;
    int m_ticks;
    bit m_ew;
    bit m_ped;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int phase_len(input int p);
        case (p)
            P_ARB, P_ARA: return ALLRED_T;
            P_NSY, P_EWY: return YELLOW_T;
            P_EWG:        return EW_GREEN;
            P_PED:        return PED_T;
            default:      return 0;
        endcase
    endfunction

    function automatic int follow(input int p);
        case (p)
            P_ARB:   return P_NSG;
            P_NSG:   return P_NSY;
            P_NSY:   return P_ARA;
            P_ARA:   return (PED_EN && m_ped) ? P_PED : P_EWG;
            P_PED:   return m_ew ? P_EWG : P_NSG;
            P_EWG:   return P_EWY;
            default: return P_ARB;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = P_ARB;
        m_ticks = 0;
        m_ew    = 1'b0;
        m_ped   = 1'b0;
    endtask

    // Advance one clock edge using the inputs presented before the edge
    task automatic model_step(input bit tick, input bit ew, input bit ped);
        bit leave;
        int nxt;
        leave = 1'b0;
        nxt   = follow(m_phase);
        if (tick) begin
            if (m_phase == P_NSG)
                leave = (m_ticks + 1 >= MIN_GREEN) && (m_ew || m_ped);
            else
                leave = (m_ticks + 1 == phase_len(m_phase));
        end
        if (leave && nxt == P_EWG)                 m_ew = 1'b0;
        else if (ew && m_phase != P_EWG && m_phase != P_EWY) m_ew = 1'b1;
        if (PED_EN) begin
            if (leave && nxt == P_PED)             m_ped = 1'b0;
            else if (ped && m_phase != P_PED)      m_ped = 1'b1;
        end
        if (leave) begin
            m_phase = nxt;
            m_ticks = 0;
        end else if (tick) begin
            m_ticks++;
        end
    endtask

    task automatic check_outputs();
        logic [1:0] ns_exp, ew_exp;
        ns_exp = (m_phase == P_NSG) ? 2'b01 : (m_phase == P_NSY) ? 2'b10 : 2'b00;
        ew_exp = (m_phase == P_EWG) ? 2'b01 : (m_phase == P_EWY) ? 2'b10 : 2'b00;
        check("phase",    32'(u_if.phase),    32'(m_phase));
        check("ns_light", 32'(u_if.ns_light), 32'(ns_exp));
        check("ew_light", 32'(u_if.ew_light), 32'(ew_exp));
        check("walk",     32'(u_if.walk),     32'(m_phase == P_PED));
        check("excl", 32'(u_if.ns_light != 2'b00 && u_if.ew_light != 2'b00), 32'd0);
        check("walk_red", 32'(u_if.walk && (u_if.ns_light != 2'b00 || u_if.ew_light != 2'b00)), 32'd0);
    endtask

    // One clock: inputs already driven; edge, model, then check at negedge
    task automatic cycle();
        bit t, e, p;
        t = u_if.tick_en;
        e = u_if.ew_req;
        p = u_if.ped_req;
        @(posedge clk);
        model_step(t, e, p);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset(input int ncyc);
        rstb = 1'b0;
        u_if.ew_req  = 1'b0;
        u_if.ped_req = 1'b0;
        #1;
        model_reset();
        check("rst_phase", 32'(u_if.phase), 32'd0);
        check("rst_lights", 32'({u_if.ns_light, u_if.ew_light}), 32'd0);
        check("rst_walk", 32'(u_if.walk), 32'd0);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs();
        end
        rstb = 1'b1;
    endtask

    initial begin
        u_if.tick_en = 1'b1;
        u_if.ew_req  = 1'b0;
        u_if.ped_req = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(3);

        // Idle: all-red clearance then green rests
        for (int i = 0; i < 52; i++) cycle();
        check("idle_green", 32'(u_if.ns_light), 32'd1);

        // Single EW pulse on the 3rd NS-green cycle of a fresh run
        do_reset(1);
        for (int i = 0; i < 4; i++) cycle();
        u_if.ew_req = 1'b1;
        cycle();
        u_if.ew_req = 1'b0;
        for (int i = 0; i < 40; i++) cycle();
        check("ew_done_green", 32'(u_if.phase), 32'(P_NSG));

        // Both requests in the same cycle after the minimum green
        for (int i = 0; i < 10; i++) cycle();
        u_if.ew_req  = 1'b1;
        u_if.ped_req = 1'b1;
        cycle();
        u_if.ew_req  = 1'b0;
        u_if.ped_req = 1'b0;
        for (int i = 0; i < 40; i++) cycle();

        // Pedestrian pulses only
        for (int i = 0; i < 60; i++) begin
            u_if.ped_req = ($urandom_range(0, 7) == 0);
            cycle();
        end
        u_if.ped_req = 1'b0;
        for (int i = 0; i < 30; i++) cycle();

        // Slow strobe: one tick every four cycles
        for (int i = 0; i < 240; i++) begin
            u_if.tick_en = (i % 4 == 3);
            u_if.ew_req  = (i == 50);
            cycle();
        end
        u_if.ew_req = 1'b0;

        // Fully randomized traffic
        for (int i = 0; i < 2500; i++) begin
            u_if.tick_en = ($urandom_range(0, 3) != 0);
            u_if.ew_req  = ($urandom_range(0, 24) == 0);
            u_if.ped_req = ($urandom_range(0, 29) == 0);
            cycle();
        end

        // Reset asserted in the middle of EW green
        begin
            int budget;
            budget = 0;
            u_if.tick_en = 1'b1;
            u_if.ped_req = 1'b0;
            while (m_phase != P_EWG && budget < 200) begin
                u_if.ew_req = 1'b1;
                cycle();
                budget++;
            end
            u_if.ew_req = 1'b0;
            check("reach_ew_green", 32'(m_phase == P_EWG), 32'd1);
            cycle();
        end
        u_if.ew_req = 1'b1;
        do_reset(2);
        u_if.ew_req = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        check("post_rst_green", 32'(u_if.ns_light), 32'd1);

        for (int i = 0; i < 500; i++) begin
            u_if.tick_en = ($urandom_range(0, 1) != 0);
            u_if.ew_req  = ($urandom_range(0, 15) == 0);
            u_if.ped_req = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
